fetch_control: RTL

//  Fetch/decode/control stage directly upstream of the datapath in the 5-instruction Harvard CPU.

---
 rtl/fetch_control.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_control.sv
// fetch_control
//   Fetch/decode/control stage of the 5-instruction Harvard CPU (ADDU, ADDIU, LW, SW, JR).
//   It owns the PC and instruction register and runs the instruction-memory handshake.
//   It decodes IR into datapath fields and control strobes.
//   It sequences data-memory stalls and JR with a single branch delay slot.
//   The CPU halts when a JR targets address 0.
//
// Parameters
//   RESET_VECTOR       PC loaded on reset
//
// Ports
//   clk                single clock, all state on posedge
//   reset              synchronous active-low reset (0 = reset)
//   instr_address      PC, valid while instr_read=1
//   instr_read         instruction fetch request
//   instr_waitrequest  1 = imem not ready, request held
//   instr_readdata     instruction word, captured on instr_read & !instr_waitrequest
//   data_read          LW request to dmem
//   data_write         SW request to dmem
//   data_waitrequest   1 = dmem not ready, request held
//   reg_read_data_0    rs value from the datapath (JR target)
//   rs, rt, rd         IR[25:21], IR[20:16], IR[15:11]
//   ALUOp              IR[31:26]
//   func_code          IR[5:0]
//   alu_immediate      IR[15:0]
//   RegDst             1 = write rt, 0 = write rd
//   ALUSrc             1 = sign-extended immediate as op2
//   MemtoReg           1 = write-back from data memory
//   RegWrite           register file write enable, pulses in the completing cycle
//   active             1 = running, 0 = in reset or halted
//   illegal_instr      (ILLEGAL_TRAP_EN only) sticky flag, set when an undecoded instruction halts the CPU
//
// Configuration macro
//   ILLEGAL_TRAP_EN    when defined, undecoded instructions halt the CPU and set illegal_instr.
//                      When undefined, undecoded instructions execute as NOPs.

module fetch_control #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] instr_address,
   output logic        instr_read,
   input  logic        instr_waitrequest,
   input  logic [31:0] instr_readdata,
   output logic        data_read,
   output logic        data_write,
   input  logic        data_waitrequest,
   input  logic [31:0] reg_read_data_0,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [5:0]  ALUOp,
   output logic [5:0]  func_code,
   output logic [15:0] alu_immediate,
   output logic        RegDst,
   output logic        ALUSrc,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        active
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic        illegal_instr
`endif
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_EXEC   = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic        delay_pending_q, delay_pending_d;
   logic [31:0] target_q, target_d;
   logic        illegal_q, illegal_d;

   logic [5:0]  opcode_s;
   logic [5:0]  funct_s;
   logic        is_addu_s, is_addiu_s, is_lw_s, is_sw_s, is_jr_s;
   logic        exec_done_s;
`ifdef ILLEGAL_TRAP_EN
   logic        is_legal_s;
`endif

   // Instruction decode from IR and EXEC completion condition
   always_comb begin
      opcode_s   = ir_q[31:26];
      funct_s    = ir_q[5:0];
      is_addu_s  = (opcode_s == 6'h00) && (funct_s == 6'h21);
      is_jr_s    = (opcode_s == 6'h00) && (funct_s == 6'h08);
      is_addiu_s = (opcode_s == 6'h09);
      is_lw_s    = (opcode_s == 6'h23);
      is_sw_s    = (opcode_s == 6'h2B);
`ifdef ILLEGAL_TRAP_EN
      is_legal_s = is_addu_s || is_jr_s || is_addiu_s || is_lw_s || is_sw_s;
`endif
      // Memory instructions finish only once dmem accepts; everything else takes one cycle
      exec_done_s = (state_q == S_EXEC) && (!(is_lw_s || is_sw_s) || !data_waitrequest);
   end

   // Next-state logic: fetch capture, PC update and delay-slot sequencing
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      ir_d            = ir_q;
      delay_pending_d = delay_pending_q;
      target_d        = target_q;
      illegal_d       = illegal_q;
      case (state_q)
         S_FETCH: begin
            if (!instr_waitrequest) begin
               ir_d    = instr_readdata;
               state_d = S_EXEC;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_EXEC: begin
            if (exec_done_s) begin
               if (delay_pending_q) begin
                  // Delay slot finished: take the jump. A JR sitting here is a NOP.
                  pc_d            = target_q;
                  delay_pending_d = 1'b0;
                  if (target_q == 32'h0000_0000) begin
                     state_d = S_HALTED;
                  end else begin
                     state_d = S_FETCH;
                  end
               end else if (is_jr_s) begin
                  pc_d            = pc_q + 32'd4;
                  delay_pending_d = 1'b1;
                  target_d        = reg_read_data_0;
                  state_d         = S_FETCH;
               end else begin
                  pc_d    = pc_q + 32'd4;
                  state_d = S_FETCH;
               end
`ifdef ILLEGAL_TRAP_EN
               if (!is_legal_s) begin
                  state_d   = S_HALTED;
                  illegal_d = 1'b1;
               end
`endif
            end else begin
               state_d = S_EXEC;
            end
         end
         S_HALTED: begin
            state_d = S_HALTED;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= S_FETCH;
         pc_q            <= RESET_VECTOR;
         ir_q            <= 32'h0000_0000;
         delay_pending_q <= 1'b0;
         target_q        <= 32'h0000_0000;
         illegal_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         ir_q            <= ir_d;
         delay_pending_q <= delay_pending_d;
         target_q        <= target_d;
         illegal_q       <= illegal_d;
      end
   end

   // Output decode; reset gates everything so pending requests drop in the reset cycle itself
   always_comb begin
      instr_address = pc_q;
      instr_read    = reset && (state_q == S_FETCH);
      data_read     = reset && (state_q == S_EXEC) && is_lw_s;
      data_write    = reset && (state_q == S_EXEC) && is_sw_s;
      RegWrite      = reset && exec_done_s && (is_addu_s || is_addiu_s || is_lw_s);
      active        = reset && (state_q != S_HALTED);
      if (reset) begin
         rs            = ir_q[25:21];
         rt            = ir_q[20:16];
         rd            = ir_q[15:11];
         ALUOp         = ir_q[31:26];
         func_code     = ir_q[5:0];
         alu_immediate = ir_q[15:0];
         RegDst        = is_addiu_s || is_lw_s;
         ALUSrc        = is_addiu_s || is_lw_s || is_sw_s;
         MemtoReg      = is_lw_s;
      end else begin
         rs            = 5'd0;
         rt            = 5'd0;
         rd            = 5'd0;
         ALUOp         = 6'd0;
         func_code     = 6'd0;
         alu_immediate = 16'd0;
         RegDst        = 1'b0;
         ALUSrc        = 1'b0;
         MemtoReg      = 1'b0;
      end
`ifdef ILLEGAL_TRAP_EN
      illegal_instr = reset && illegal_q;
`endif
   end

endmodule
